ripple_count_sampler: RTL

RIPPLE_COUNT_SAMPLER -- requirements
Module: ripple_count_sampler

---
 rtl/ripple_count_sampler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ripple_count_sampler.sv
// Samples a free-running 4-bit ripple counter, keeps only values that have settled, and extends
// them into a wide count. The result goes out on a valid/ready port, and updates are merged while the port is stalled.
module ripple_count_sampler #(
  parameter int SETTLE_CYCLES = 2,
  parameter int EXT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           q_in,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [EXT_WIDTH-1:0] out_count,
  output logic                 out_wrapped,
  output logic                 settled
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

  state_t               state_q, state_d;
  logic [3:0]           sync1_q, sync1_d;
  logic [3:0]           sync2_q, sync2_d;
  logic [3:0]           prev_q, prev_d;
  logic [3:0]           stab_q, stab_d;
  logic                 settled_q, settled_d;
  logic [3:0]           s_val_q, s_val_d;
  logic [3:0]           last_val_q, last_val_d;
  logic [EXT_WIDTH-1:0] ext_q, ext_d;
  logic                 pwrap_q, pwrap_d;
  logic [EXT_WIDTH-1:0] out_count_q, out_count_d;
  logic                 out_wrapped_q, out_wrapped_d;

  logic [3:0]           delta;
  logic                 wrap_now;
  logic                 acc;
  logic                 hs;
  logic                 pw_merge;
  logic [EXT_WIDTH-1:0] ext_sum;

  // Sampling path: the settle decision is combinational so that an accepted value
  // reaches the output port in the same edge the counter saturates.
  always_comb begin
    sync1_d = q_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    if (sync2_q != prev_q) begin
      stab_d = 4'd0;
    end else if (stab_q == SETTLE_L) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + 4'd1;
    end

    settled_d = (stab_d == SETTLE_L);
    s_val_d   = settled_d ? sync2_q : s_val_q;

    delta    = s_val_d - last_val_q;
    wrap_now = (s_val_d < last_val_q);
    acc      = settled_d && enable && !clear && (s_val_d != last_val_q);
    ext_sum  = ext_q + EXT_WIDTH'(delta);

    // While disabled the baseline follows the input so that skipped motion is never counted.
    if (clear || !enable || acc) begin
      last_val_d = s_val_d;
    end else begin
      last_val_d = last_val_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ext_d         = ext_q;
    pwrap_d       = pwrap_q;
    out_count_d   = out_count_q;
    out_wrapped_d = out_wrapped_q;
    hs            = (state_q != IDLE) && out_ready;
    pw_merge      = pwrap_q | (acc & wrap_now);

    if (clear) begin
      state_d = IDLE;
      ext_d   = '0;
      pwrap_d = 1'b0;
    end else begin
      if (acc) begin
        ext_d = ext_sum;
      end
      case (state_q)
        IDLE: begin
          if (acc) begin
            out_count_d   = ext_d;
            out_wrapped_d = pw_merge;
            pwrap_d       = 1'b0;
            state_d       = PRESENT;
          end
        end
        PRESENT: begin
          if (hs && acc) begin
            out_count_d   = ext_d;
            out_wrapped_d = pw_merge;
            pwrap_d       = 1'b0;
          end else if (hs) begin
            state_d = IDLE;
          end else if (acc) begin
            pwrap_d = pw_merge;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (hs) begin
            out_count_d   = ext_d;
            out_wrapped_d = pw_merge;
            pwrap_d       = 1'b0;
            state_d       = PRESENT;
          end else begin
            pwrap_d = pw_merge;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q       <= 4'd0;
      sync2_q       <= 4'd0;
      prev_q        <= 4'd0;
      stab_q        <= 4'd0;
      settled_q     <= 1'b0;
      s_val_q       <= 4'd0;
      last_val_q    <= 4'd0;
      ext_q         <= '0;
      pwrap_q       <= 1'b0;
      out_count_q   <= '0;
      out_wrapped_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      stab_q        <= stab_d;
      settled_q     <= settled_d;
      s_val_q       <= s_val_d;
      last_val_q    <= last_val_d;
      ext_q         <= ext_d;
      pwrap_q       <= pwrap_d;
      out_count_q   <= out_count_d;
      out_wrapped_q <= out_wrapped_d;
    end
  end

  always_comb begin
    out_valid   = (state_q != IDLE);
    out_count   = out_count_q;
    out_wrapped = out_wrapped_q;
    settled     = settled_q;
  end

endmodule
